// File: rtl/xalu_nibble_seq.sv
// rtl/xalu_nibble_seq.sv - multi-nibble sequencer driving a combinational 4-bit xalu slice
//
// Issues a 4*NIBBLES-bit operation to the slice one nibble per clock, chaining the
// carry/shift bit through carry_reg, and returns the assembled result on a
// valid/ready handshake.
//
// Optional feature macro: XALU_SEQ_EQU_EN (full-width A==B flag from alu_equ).
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready only in IDLE)
//   cmd_a, cmd_b             operands, 4*NIBBLES bits
//   cmd_f, cmd_com, cmd_cin  function code, complement-output mode, carry/shift-in
//   alu_a, alu_b, alu_f,
//   alu_com, alu_ci_right,
//   alu_ci_left              nibble-level drive to the slice (0 outside RUN)
//   alu_d, alu_co_left,
//   alu_co_right, alu_zero,
//   alu_equ                  slice outputs, sampled in the cycle they are driven
//   res_valid/res_ready      result handshake
//   res_d, res_cout,
//   res_zero, res_equ        assembled result, final carry, zero and A==B flags

module xalu_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [4*NIBBLES-1:0]   cmd_a,
  input  logic [4*NIBBLES-1:0]   cmd_b,
  input  logic [2:0]             cmd_f,
  input  logic                   cmd_com,
  input  logic                   cmd_cin,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [2:0]             alu_f,
  output logic                   alu_com,
  output logic                   alu_ci_right,
  output logic                   alu_ci_left,
  input  logic [3:0]             alu_d,
  input  logic                   alu_co_left,
  input  logic                   alu_co_right,
  input  logic                   alu_zero,
  input  logic                   alu_equ,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4*NIBBLES-1:0]   res_d,
  output logic                   res_cout,
  output logic                   res_zero,
  output logic                   res_equ
);

  localparam int WIDTH = 4 * NIBBLES;
  localparam int IDXW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  localparam logic [2:0] F_ADD = 3'd0;
  localparam logic [2:0] F_SHR = 3'd6;
  localparam logic [2:0] F_SHL = 3'd7;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  a_reg, b_reg;
  logic [2:0]        f_reg;
  logic              com_reg;
  logic              carry_reg;
  logic              zero_acc;
  logic [IDXW-1:0]   idx;
  logic [IDXW+1:0]   bit_base;
  logic              accept;
  logic              last_nib;
  logic              is_shr;
  logic              left_chain;   // ADD/SHL: carry travels toward the MSB
  logic              carry_nxt;

  assign accept     = cmd_valid && (state == IDLE);
  assign is_shr     = (f_reg == F_SHR);
  assign left_chain = (f_reg == F_ADD) || (f_reg == F_SHL);
  assign bit_base   = {idx, 2'b00};
  // SHR walks MSB-first, so its final nibble is index 0.
  assign last_nib   = is_shr ? (idx == '0) : (idx == LAST_IDX);
  assign carry_nxt  = is_shr ? alu_co_right : alu_co_left;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = RUN;
      RUN:     if (last_nib) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: slice is only driven while a nibble is in flight
  always_comb begin
    cmd_ready    = (state == IDLE);
    res_valid    = (state == DONE);
    alu_a        = 4'd0;
    alu_b        = 4'd0;
    alu_f        = 3'd0;
    alu_com      = 1'b0;
    alu_ci_right = 1'b0;
    alu_ci_left  = 1'b0;
    if (state == RUN) begin
      alu_a        = a_reg[bit_base +: 4];
      alu_b        = b_reg[bit_base +: 4];
      alu_f        = f_reg;
      alu_com      = com_reg;
      alu_ci_right = left_chain ? carry_reg : 1'b0;
      alu_ci_left  = is_shr ? carry_reg : 1'b0;
    end
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      f_reg     <= 3'd0;
      com_reg   <= 1'b0;
      carry_reg <= 1'b0;
      zero_acc  <= 1'b0;
      idx       <= '0;
      res_d     <= '0;
      res_cout  <= 1'b0;
      res_zero  <= 1'b0;
    end else if (accept) begin
      a_reg     <= cmd_a;
      b_reg     <= cmd_b;
      f_reg     <= cmd_f;
      com_reg   <= cmd_com;
      carry_reg <= cmd_cin;
      zero_acc  <= 1'b1;
      idx       <= (cmd_f == F_SHR) ? LAST_IDX : '0;
    end else if (state == RUN) begin
      res_d[bit_base +: 4] <= alu_d;
      zero_acc <= zero_acc & alu_zero;
      if (left_chain || is_shr) carry_reg <= carry_nxt;
      if (last_nib) begin
        // Logic ops never produce a carry, whatever the slice reports.
        res_cout <= (left_chain || is_shr) ? carry_nxt : 1'b0;
        res_zero <= zero_acc & alu_zero;
      end
      if (!last_nib) idx <= is_shr ? idx - 1'b1 : idx + 1'b1;
    end
  end

`ifdef XALU_SEQ_EQU_EN
  logic equ_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      equ_acc <= 1'b0;
      res_equ <= 1'b0;
    end else if (accept) begin
      equ_acc <= 1'b1;
    end else if (state == RUN) begin
      equ_acc <= equ_acc & alu_equ;
      if (last_nib) res_equ <= equ_acc & alu_equ;
    end
  end
`else
  logic unused_equ;
  assign unused_equ = alu_equ;
  assign res_equ    = 1'b0;
`endif

endmodule
